mod_addsub_seq: RTL and testbench

MOD_ADDSUB_SEQ -- requirements
Module: mod_addsub_seq

---
 rtl/mod_addsub_seq_pkg.sv | 14 +
 rtl/mpadder1.sv | 22 ++
 rtl/mod_addsub_seq.sv | 168 ++++++++++++++++
 tb/tb_mod_addsub_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_addsub_seq_pkg.sv
// Shared widths and FSM encoding for the sequential modular add/subtract unit.
package mod_addsub_seq_pkg;

  localparam int OPW = 1024;
  localparam int ADW = 1027;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STEP1  = 2'b01,
    ST_STEP2  = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/mpadder1.sv
// Combinational wide adder/subtractor; the extra top bit carries out of (or borrows into) bit W.
module mpadder1
  import mod_addsub_seq_pkg::*;
#(
  parameter int W = ADW
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         subtract,
  output logic [W:0]   result
);

  // Add or subtract with one bit of headroom
  always_comb begin
    if (subtract) begin
      result = {1'b0, in_a} - {1'b0, in_b};
    end else begin
      result = {1'b0, in_a} + {1'b0, in_b};
    end
  end

endmodule

// File: rtl/mod_addsub_seq.sv
// Three-step (a +/- b) mod M using one shared adder: s1 = a +/- b, s2 = s1 -/+ M, then a sign-based pick.
module mod_addsub_seq
  import mod_addsub_seq_pkg::*;
#(
  parameter int OPW = mod_addsub_seq_pkg::OPW,
  parameter int ADW = mod_addsub_seq_pkg::ADW
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           subtract,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic [OPW-1:0] in_m,
  output logic [OPW-1:0] result,
  output logic           done,
  output logic           busy
);

  localparam int EXT = ADW - OPW;

  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic           sub_q, sub_d, done_q, done_d, busy_q, busy_d;
  logic [ADW-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [ADW-1:0] add_x_s, add_y_s, sum_s;
  logic [ADW:0]   add_res_s;
  logic           add_sub_s;
  logic           add_unused_s;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STEP1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP1:  state_d = ST_STEP2;
      ST_STEP2:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Adder operand mux: STEP2 applies the modulus correction in the opposite direction
  always_comb begin
    add_x_s   = {{EXT{1'b0}}, a_q};
    add_y_s   = {{EXT{1'b0}}, b_q};
    add_sub_s = sub_q;
    if (state_q == ST_STEP2) begin
      add_x_s   = s1_q;
      add_y_s   = {{EXT{1'b0}}, m_q};
      add_sub_s = ~sub_q;
    end else begin
      add_x_s   = {{EXT{1'b0}}, a_q};
      add_y_s   = {{EXT{1'b0}}, b_q};
      add_sub_s = sub_q;
    end
  end

  mpadder1 #(.W(ADW)) u_adder (
    .in_a     (add_x_s),
    .in_b     (add_y_s),
    .subtract (add_sub_s),
    .result   (add_res_s)
  );

  assign sum_s        = add_res_s[ADW-1:0];
  assign add_unused_s = add_res_s[ADW];

  // Output and datapath next-state logic
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    sub_d    = sub_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d    = in_a;
          b_d    = in_b;
          m_d    = in_m;
          sub_d  = subtract;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_STEP1: begin
        s1_d   = sum_s;
        busy_d = 1'b1;
      end
      ST_STEP2: begin
        s2_d   = sum_s;
        busy_d = 1'b1;
      end
      ST_FINISH: begin
        // Add: keep s1 unless s1-M is non-negative. Subtract: fold back by M only if s1 went negative.
        if (sub_q) begin
          if (s1_q[ADW-1]) begin
            result_d = s2_q[OPW-1:0];
          end else begin
            result_d = s1_q[OPW-1:0];
          end
        end else begin
          if (s2_q[ADW-1]) begin
            result_d = s1_q[OPW-1:0];
          end else begin
            result_d = s2_q[OPW-1:0];
          end
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      sub_q    <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      sub_q    <= sub_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed-table and random self-checking bench for mod_addsub_seq.
module tb_mod_addsub_seq;

  localparam int OPW = 1024;
  localparam int ADW = 1027;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           subtract = 1'b0;
  logic [OPW-1:0] in_a = '0;
  logic [OPW-1:0] in_b = '0;
  logic [OPW-1:0] in_m = '0;
  logic [OPW-1:0] result;
  logic           done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           sub;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] m;
    logic [OPW-1:0] exp;
  } vec_t;

  vec_t           vecs [12];
  logic [OPW-1:0] big_m;

  mod_addsub_seq #(.OPW(OPW), .ADW(ADW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  // Call at #1 after an edge with the DUT idle; returns #1 after the done edge (or one edge later).
  task automatic do_op(input logic sub, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                       input logic [OPW-1:0] m, input logic [OPW-1:0] exp, input bit chk_fall,
                       input string tag);
    subtract = sub; in_a = a; in_b = b; in_m = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_a = ~a; in_b = ~b; in_m = '0; subtract = ~sub;
    for (int c = 0; c < 3; c++) begin
      check_val({tag, "_busy"}, busy, 1'b1);
      check_val({tag, "_done_early"}, done, 1'b0);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check_val({tag, "_done"}, done, 1'b1);
    check_val({tag, "_busy_end"}, busy, 1'b0);
    check_val({tag, "_result"}, result, exp);
    if (chk_fall) begin
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, done, 1'b0);
      check_val({tag, "_hold"}, result, exp);
    end
  endtask

  initial begin
    logic [OPW-1:0] ra, rb, rm, rexp;
    logic [ADW-1:0] t;
    logic           rsub;

    big_m = '1;
    vecs[0]  = '{1'b0, 1024'd7,  1024'd9,  1024'd13, 1024'd3};
    vecs[1]  = '{1'b1, 1024'd3,  1024'd9,  1024'd13, 1024'd7};
    vecs[2]  = '{1'b1, 1024'd9,  1024'd9,  1024'd13, 1024'd0};
    vecs[3]  = '{1'b0, big_m - 1024'd1, big_m - 1024'd1, big_m, big_m - 1024'd2};
    vecs[4]  = '{1'b0, 1024'd0,  1024'd0,  1024'd13, 1024'd0};
    vecs[5]  = '{1'b0, 1024'd12, 1024'd1,  1024'd13, 1024'd0};
    vecs[6]  = '{1'b0, 1024'd12, 1024'd0,  1024'd13, 1024'd12};
    vecs[7]  = '{1'b1, 1024'd0,  1024'd12, 1024'd13, 1024'd1};
    vecs[8]  = '{1'b1, 1024'd12, 1024'd0,  1024'd13, 1024'd12};
    vecs[9]  = '{1'b1, 1024'd0,  big_m - 1024'd1, big_m, 1024'd1};
    vecs[10] = '{1'b0, 1024'd6,  1024'd6,  1024'd13, 1024'd12};
    vecs[11] = '{1'b0, 1024'd2,  1024'd2,  1024'd3,  1024'd1};

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_result", result, '0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    resetn = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, 1'b1, $sformatf("vec%0d", i));
    end

    // Start pulses while busy are ignored
    subtract = 1'b0; in_a = 1024'd7; in_b = 1024'd9; in_m = 1024'd13; start = 1'b1;
    @(posedge clk); #1;
    in_a = 1024'd1; in_b = 1024'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("ign_busy", busy, 1'b1);
    @(posedge clk); #1;
    check_val("ign_done_early", done, 1'b0);
    @(posedge clk); #1;
    check_val("ign_done", done, 1'b1);
    check_val("ign_result", result, 1024'd3);
    @(posedge clk); #1;
    check_val("ign_no_requeue_done", done, 1'b0);
    check_val("ign_no_requeue_busy", busy, 1'b0);

    // Start held high: back-to-back operations, mid-op input changes ignored
    subtract = 1'b0; in_a = 1024'd1; in_b = 1024'd1; in_m = 1024'd13; start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      @(posedge clk); #1;
      check_val($sformatf("b2b%0d_busy", op), busy, 1'b1);
      check_val($sformatf("b2b%0d_done0", op), done, 1'b0);
      in_a = 1024'd7;
      @(posedge clk); #1;
      check_val($sformatf("b2b%0d_done1", op), done, 1'b0);
      @(posedge clk); #1;
      in_a = 1024'd1;
      check_val($sformatf("b2b%0d_done2", op), done, 1'b0);
      @(posedge clk); #1;
      check_val($sformatf("b2b%0d_done", op), done, 1'b1);
      check_val($sformatf("b2b%0d_result", op), result, 1024'd2);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_val("b2b_stop_busy", busy, 1'b0);
    check_val("b2b_stop_done", done, 1'b0);

    // Reset during STEP2 aborts without a done pulse
    subtract = 1'b0; in_a = 1024'd7; in_b = 1024'd9; in_m = 1024'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check_val("abort_done", done, 1'b0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_result", result, '0);
    @(posedge clk); #1;
    check_val("abort_no_done", done, 1'b0);
    resetn = 1'b1;
    do_op(1'b0, 1024'd5, 1024'd4, 1024'd13, 1024'd9, 1'b1, "after_rst");

    // Random operands against a compare-and-correct reference
    for (int n = 0; n < 10000; n++) begin
      for (int w = 0; w < OPW / 32; w++) begin
        rm[w*32 +: 32] = $urandom();
        ra[w*32 +: 32] = $urandom();
        rb[w*32 +: 32] = $urandom();
      end
      rm[OPW-1] = 1'b1;
      rm[0]     = 1'b1;
      if (ra >= rm) ra = ra - rm;
      if (rb >= rm) rb = rb - rm;
      rsub = n[0];
      if (rsub) begin
        if (ra >= rb) rexp = ra - rb;
        else          rexp = ra - rb + rm;
      end else begin
        t = {3'b000, ra} + {3'b000, rb};
        if (t >= {3'b000, rm}) t = t - {3'b000, rm};
        rexp = t[OPW-1:0];
      end
      do_op(rsub, ra, rb, rm, rexp, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
